kernel_loader: RTL and testbench
================================

Name: kernel_loader

Overview:
- Upstream feeder for the 9-entry kernel register file.
- Accepts a stream of kernel weights over a valid/ready handshake after a start pulse.
- Writes taps 0..KERNEL_TAPS-1 into the register file through its write port (write address, data, write enable).
- Signals completion with a done pulse and a kernel_valid level that the convolution datapath uses as its go condition.

Parameters:
- WIDTH, 16, weight width; must match the kernel register file WIDTH.
- KERNEL_TAPS, 9, number of weights per kernel, in the range 1..32.
- ADDR_W, 5, kernel register file address width.

Ports:
- clk  input  1  clock.
- arst_n_in  input  1  reset; one clock; reset is synchronous and active-low.
- start  input  1  one-cycle request to (re)load the kernel.
- in_data  input  WIDTH  weight from upstream memory/bus.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- kreg_write_addr  output  ADDR_W  to kernel register file write_addr.
- kreg_din  output  WIDTH  to kernel register file din.
- kreg_write_en  output  1  to kernel register file write_en.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse: all taps committed.
- kernel_valid  output  1  level: full kernel present in the register file.

Behaviour:
- Reset (arst_n_in low at a clk edge) forces these values:
  - state IDLE, tap counter 0.
  - in_ready 0, kreg_write_en 0, kreg_write_addr 0, kreg_din 0.
  - busy 0, done 0, kernel_valid 0.
- States:
  - IDLE: in_ready 0, busy 0. On start, go to LOAD, clear the counter, and drop kernel_valid to 0 in the next cycle.
  - LOAD: in_ready 1, busy 1.
    - Transfer occurs when in_valid and in_ready are both high at an edge.
    - On each transfer, the counter increments.
    - On the transfer of tap KERNEL_TAPS-1, go to FLUSH.
  - FLUSH: in_ready 0, busy 1. Next cycle go to IDLE with done=1 for exactly one cycle and kernel_valid=1.
- Write path:
  - All register-file outputs are registered.
  - A transfer of tap k at edge t drives kreg_write_en=1, kreg_write_addr=k and kreg_din=in_data in the cycle after t.
  - The tap is therefore committed at edge t+1.
  - kreg_write_en is 0 in every cycle without a preceding transfer.
- Latency: from the last transfer edge, the write is in the next cycle and done/kernel_valid follow one cycle later (2 cycles total).
- The tap counter never exceeds KERNEL_TAPS-1. Addresses at or above KERNEL_TAPS are never issued; there is no wrap.
- Upstream stalls (in_valid low): no write that cycle, counter holds, and there is no timeout.
- start while in LOAD or FLUSH: ignored, no restart.
- start in the done cycle (IDLE): accepted; kernel_valid falls in the next cycle.
- in_valid while in IDLE or FLUSH: no transfer, because in_ready is 0.
- Reset mid-load:
  - Immediate return to IDLE and kernel_valid 0.
  - Any write scheduled for the next cycle is dropped.
  - The register file contents are undefined to the consumer until the next complete load.
- kernel_valid only rises after all KERNEL_TAPS writes have committed; a partial load never raises it.

Decomposition:
- Shared package holds:
  - typedef enum kernel_loader_state_t {IDLE, LOAD, FLUSH}.
  - Constants KERNEL_TAPS=9 and KREG_ADDR_W=5, shared with the kernel register file instantiation.
- No sub-module: a single FSM, a counter and an output register stage.

Test Plan:
- Back-to-back load:
  - Stimulus: start, then in_valid held high with in_data=0x0011..0x0099.
  - Required: writes to addr 0..8 on 9 consecutive cycles.
  - Required: done pulse 2 cycles after the 9th handshake, with kernel_valid=1.
  - Required: reading back addr 0..8 gives 0x0011..0x0099.
- Stalled upstream:
  - Stimulus: in_valid toggles 1,0,0,1,...
  - Required: kreg_write_en high only after real transfers, addresses contiguous 0..8, and done after the 9th transfer only.
- Ignored inputs:
  - Stimulus: start repeated during LOAD and in_valid asserted in IDLE.
  - Required: counter not reset, no writes in IDLE, and in_ready=0 in IDLE.
- Reset mid-load:
  - Stimulus: drop arst_n_in after 4 transfers.
  - Required: next cycle shows state IDLE, kernel_valid=0, no write of tap 4, and done is never asserted.
  - Required: a subsequent start performs a full reload from addr 0.
- Reload after done:
  - Stimulus: start in the done cycle.
  - Required: kernel_valid falls the next cycle and rises again only after the second complete 9-tap load.

Source files
------------

// File: rtl/kernel_loader_pkg.sv
// kernel_loader_pkg: state encoding and constants shared with the kernel register file
package kernel_loader_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} kernel_loader_state_t;
    localparam int KERNEL_TAPS = 9;
    localparam int KREG_ADDR_W = 5;
endpackage

// File: rtl/kernel_loader.sv
// kernel_loader: streams KERNEL_TAPS weights into the kernel register file after a start pulse
module kernel_loader #(
    parameter int WIDTH = 16,
    parameter int KERNEL_TAPS = kernel_loader_pkg::KERNEL_TAPS,
    parameter int ADDR_W = kernel_loader_pkg::KREG_ADDR_W
) (
    input  logic              clk,
    input  logic              arst_n_in,
    input  logic              start,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] kreg_write_addr,
    output logic [WIDTH-1:0]  kreg_din,
    output logic              kreg_write_en,
    output logic              busy,
    output logic              done,
    output logic              kernel_valid
);
    import kernel_loader_pkg::*;
    kernel_loader_state_t state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic xfer, last;
    assign xfer = in_valid && in_ready;
    assign last = cnt == ADDR_W'(KERNEL_TAPS - 1);
    always_ff @(posedge clk) begin
        if (!arst_n_in) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == IDLE && start) ? LOAD :
                    (state == LOAD && xfer && last) ? FLUSH :
                    (state == FLUSH) ? IDLE : state;
    end
    always_comb begin
        in_ready = state == LOAD;
        busy = state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            cnt <= '0;
            kreg_write_en <= 1'b0;
            kreg_write_addr <= '0;
            kreg_din <= '0;
            done <= 1'b0;
            kernel_valid <= 1'b0;
        end else begin
            kreg_write_en <= xfer;
            if (xfer) begin
                kreg_write_addr <= cnt;
                kreg_din <= in_data;
            end
            done <= state == FLUSH;
            if (state == IDLE && start) begin
                cnt <= '0;
                kernel_valid <= 1'b0;
            end else if (xfer && !last) begin
                cnt <= cnt + 1'b1;
            end
            if (state == FLUSH) kernel_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_kernel_loader.sv
// tb_kernel_loader: directed checks of load, stall, ignored inputs, mid-load reset and reload
module tb_kernel_loader;
    logic clk = 1'b0;
    logic arst_n_in, start, in_valid;
    logic [15:0] in_data;
    logic in_ready, kreg_write_en, busy, done, kernel_valid;
    logic [4:0] kreg_write_addr;
    logic [15:0] kreg_din;
    logic [15:0] rf [0:31];
    int checks = 0;
    int errors = 0;
    int n;
    always #5 clk = ~clk;
    kernel_loader dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .kreg_write_addr(kreg_write_addr),
        .kreg_din(kreg_din), .kreg_write_en(kreg_write_en), .busy(busy),
        .done(done), .kernel_valid(kernel_valid)
    );
    always @(posedge clk) if (kreg_write_en) rf[kreg_write_addr] <= kreg_din;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_kv_low", kernel_valid, 0);
        check("start_ready", in_ready, 1);
    endtask
    // runs a back-to-back load from LOAD and returns in the done cycle
    task automatic run_load(input logic [15:0] base);
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_data = base + 16'(k * 16'h11);
            tick();
            check("wr_en", kreg_write_en, 1);
            check("wr_addr", kreg_write_addr, k);
            check("wr_din", kreg_din, base + 16'(k * 16'h11));
            check("load_done_low", done, 0);
            check("load_kv_low", kernel_valid, 0);
        end
        in_valid = 1'b0;
        check("flush_ready", in_ready, 0);
        check("flush_busy", busy, 1);
        tick();
        check("done_pulse", done, 1);
        check("done_kv", kernel_valid, 1);
        check("done_no_wr", kreg_write_en, 0);
        check("done_idle", busy, 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        arst_n_in = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 16'h0;
        tick();
        tick();
        check("rst_ready", in_ready, 0);
        check("rst_wen", kreg_write_en, 0);
        check("rst_addr", kreg_write_addr, 0);
        check("rst_din", kreg_din, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_kv", kernel_valid, 0);
        arst_n_in = 1'b1;
        tick();
        // back-to-back load
        do_start();
        run_load(16'h0011);
        tick();
        check("done_one_cycle", done, 0);
        check("kv_holds", kernel_valid, 1);
        for (int k = 0; k < 9; k++) check("readback", rf[k], 16'h11 * 16'(k + 1));
        // stalled upstream: valid 1,0,0 repeating
        do_start();
        n = 0;
        for (int i = 0; i < 27 && n < 9; i++) begin
            in_valid = (i % 3) == 0;
            in_data = 16'h100 + 16'(i);
            tick();
            check("stall_wen", kreg_write_en, (i % 3) == 0);
            check("stall_done_low", done, 0);
            if ((i % 3) == 0) begin
                check("stall_addr", kreg_write_addr, n);
                check("stall_din", kreg_din, 16'h100 + 16'(i));
                n++;
            end
        end
        in_valid = 1'b0;
        check("stall_count", n, 9);
        tick();
        check("stall_done", done, 1);
        check("stall_kv", kernel_valid, 1);
        // ignored inputs: in_valid in IDLE, start during LOAD
        tick();
        in_valid = 1'b1;
        in_data = 16'hdead;
        check("idle_ready", in_ready, 0);
        tick();
        check("idle_no_wr", kreg_write_en, 0);
        in_valid = 1'b0;
        do_start();
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_data = 16'h200 + 16'(k);
            start = k == 3 || k == 8;
            tick();
            check("ign_addr", kreg_write_addr, k);
            check("ign_busy", busy, 1);
        end
        start = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        check("ign_flush_start_done", done, 1);
        tick();
        check("ign_flush_start_idle", busy, 0);
        // reset mid-load
        do_start();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data = 16'h300 + 16'(k);
            tick();
        end
        check("pre_rst_addr", kreg_write_addr, 3);
        in_data = 16'h304;
        arst_n_in = 1'b0;
        tick();
        check("mid_rst_wen", kreg_write_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_kv", kernel_valid, 0);
        check("mid_rst_ready", in_ready, 0);
        arst_n_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_done", done, 0);
            check("post_rst_wen", kreg_write_en, 0);
        end
        in_valid = 1'b0;
        do_start();
        run_load(16'h0400);
        // reload requested in the done cycle
        do_start();
        run_load(16'h0500);
        tick();
        check("reload_kv", kernel_valid, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
